// File: rtl/regfile_debug_port.sv
// Debug access port for a CPU register file.
// A request halts the CPU and waits for the halt acknowledge. It then performs
// a single read, a single write or a full 32-register dump through the
// register-file ports. Results come back as a stream of response beats with
// valid/ready flow control. Once the last beat is accepted, the halt request
// is released.
module regfile_debug_port #(
    parameter int HALT_TIMEOUT = 255
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_req_valid,
    output logic        O_req_ready,
    input  logic        I_req_write,
    input  logic        I_req_dump,
    input  logic [4:0]  I_req_addr,
    input  logic [31:0] I_req_wdata,
    output logic        O_rsp_valid,
    input  logic        I_rsp_ready,
    output logic [31:0] O_rsp_data,
    output logic [4:0]  O_rsp_addr,
    output logic        O_rsp_err,
    output logic        O_rsp_last,
    output logic        O_halt_req,
    input  logic        I_halted,
    output logic [4:0]  O_rf_rs1,
    output logic [4:0]  O_rf_rs2,
    output logic [4:0]  O_rf_rd,
    output logic        O_rf_re,
    output logic        O_rf_we,
    output logic [31:0] O_rf_data,
    input  logic [31:0] I_rf_regval1,
    input  logic [31:0] I_rf_regval2
);

    // The wait counter only has to reach HALT_TIMEOUT-1; the timeout fires on that count.
    localparam int WAIT_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HALT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HALT    = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_started;
    logic               r_write;
    logic               r_dump;
    logic [4:0]         r_addr;
    logic [31:0]        r_wdata;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_cap_wait;
    logic [3:0]         r_pair;
    logic               r_beat;
    logic [31:0]        r_cap2;

    logic               r_rsp_valid;
    logic [31:0]        r_rsp_data;
    logic [4:0]         r_rsp_addr;
    logic               r_rsp_err;
    logic               r_rsp_last;

    logic               w_accept;
    logic               w_rsp_hs;
    logic               w_timeout;
    logic               w_issue_en;
    logic               w_single_wr;
    logic               w_cap_done;

    // A request is taken only in IDLE, and only once the first clock after reset has passed.
    assign w_accept    = O_req_ready & I_req_valid;
    assign w_rsp_hs    = r_rsp_valid & I_rsp_ready;
    assign w_timeout   = (r_state == S_HALT) & ~I_halted & (r_wait == WAIT_MAX);
    // Register-file ports are touched only while the CPU confirms it is halted.
    assign w_issue_en  = (r_state == S_ISSUE) & I_halted;
    assign w_single_wr = ~r_dump & r_write;
    assign w_cap_done  = (r_state == S_CAPTURE) & r_cap_wait;

    // State register.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_HALT;
            end
            S_HALT: begin
                if (I_halted)       w_state_nxt = S_ISSUE;
                else if (w_timeout) w_state_nxt = S_RESP;
            end
            S_ISSUE: begin
                // Stay here until the CPU confirms the halt again; the request is never abandoned.
                if (I_halted) w_state_nxt = w_single_wr ? S_RESP : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (r_cap_wait) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    if (r_rsp_last)          w_state_nxt = S_RELEASE;
                    else if (r_dump && r_beat) w_state_nxt = S_ISSUE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: handshake, halt request and register-file port drive.
    always_comb begin
        O_req_ready = r_started & (r_state == S_IDLE);
        O_halt_req  = (r_state == S_HALT) | (r_state == S_ISSUE) |
                      (r_state == S_CAPTURE) | (r_state == S_RESP);
        O_rf_re     = w_issue_en & ~w_single_wr;
        O_rf_we     = w_issue_en & w_single_wr & (r_addr != 5'd0);
        O_rf_rs1    = 5'd0;
        O_rf_rs2    = 5'd0;
        O_rf_rd     = 5'd0;
        O_rf_data   = 32'd0;
        if (O_rf_re) begin
            O_rf_rs1 = r_dump ? {r_pair, 1'b0} : r_addr;
            O_rf_rs2 = r_dump ? {r_pair, 1'b1} : 5'd0;
        end
        if (O_rf_we) begin
            O_rf_rd   = r_addr;
            O_rf_data = r_wdata;
        end
    end

    // Marks the first clock after reset release so the port does not advertise readiness in reset.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    // Request latch; a dump request masks the write flag.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_write <= 1'b0;
            r_dump  <= 1'b0;
            r_addr  <= 5'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_write <= I_req_write & ~I_req_dump;
            r_dump  <= I_req_dump;
            r_addr  <= I_req_addr;
            r_wdata <= I_req_wdata;
        end
    end

    // Halt wait counter: restarts on every accepted request and counts cycles without acknowledge.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_wait <= '0;
        end else if (w_accept) begin
            r_wait <= '0;
        end else if ((r_state == S_HALT) && !I_halted && !w_timeout) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // Capture delay: registered read data is valid one cycle after the read enable.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_cap_wait <= 1'b0;
        end else if (w_issue_en) begin
            r_cap_wait <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            r_cap_wait <= 1'b1;
        end
    end

    // Dump sequencing: pair index and which beat of the pair is presented.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_pair <= 4'd0;
            r_beat <= 1'b0;
            r_cap2 <= 32'd0;
        end else if (w_accept) begin
            r_pair <= 4'd0;
            r_beat <= 1'b0;
        end else if (w_cap_done) begin
            r_beat <= 1'b0;
            r_cap2 <= I_rf_regval2;
        end else if ((r_state == S_RESP) && w_rsp_hs && r_dump && !r_rsp_last) begin
            // The pair index never advances past 15: beat 31 is the last and leaves via RELEASE.
            if (r_beat) r_pair <= r_pair + 1'b1;
            r_beat <= ~r_beat;
        end
    end

    // Response beat register: loaded on entry to RESP, held while stalled, cleared when consumed.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_addr  <= 5'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 32'd0;
            r_rsp_addr  <= r_addr;
            r_rsp_err   <= 1'b1;
            r_rsp_last  <= 1'b1;
        end else if (w_issue_en && w_single_wr) begin
            // Writing x0 is refused with an error beat and no write strobe.
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 32'd0;
            r_rsp_addr  <= r_addr;
            r_rsp_err   <= (r_addr == 5'd0);
            r_rsp_last  <= 1'b1;
        end else if (w_cap_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            if (r_dump) begin
                // x0 is architecturally zero regardless of what the port returns.
                r_rsp_data <= (r_pair == 4'd0) ? 32'd0 : I_rf_regval1;
                r_rsp_addr <= {r_pair, 1'b0};
                r_rsp_last <= 1'b0;
            end else begin
                r_rsp_data <= I_rf_regval1;
                r_rsp_addr <= r_addr;
                r_rsp_last <= 1'b1;
            end
        end else if ((r_state == S_RESP) && w_rsp_hs) begin
            if (r_dump && !r_beat && !r_rsp_last) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_cap2;
                r_rsp_addr  <= {r_pair, 1'b1};
                r_rsp_err   <= 1'b0;
                r_rsp_last  <= (r_pair == 4'd15);
            end else begin
                r_rsp_valid <= 1'b0;
                r_rsp_data  <= 32'd0;
                r_rsp_addr  <= 5'd0;
                r_rsp_err   <= 1'b0;
                r_rsp_last  <= 1'b0;
            end
        end
    end

    assign O_rsp_valid = r_rsp_valid;
    assign O_rsp_data  = r_rsp_data;
    assign O_rsp_addr  = r_rsp_addr;
    assign O_rsp_err   = r_rsp_err;
    assign O_rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Bench for regfile_debug_port: a behavioural register file sits on the
// register-file ports and a reference model predicts every response beat
// from the request alone.
module tb_regfile_debug_port;

    localparam int TMO = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        err;
        logic        last;
    } beat_t;

    logic        I_clk = 1'b0;
    logic        I_rst_n;
    logic        I_req_valid;
    logic        O_req_ready;
    logic        I_req_write;
    logic        I_req_dump;
    logic [4:0]  I_req_addr;
    logic [31:0] I_req_wdata;
    logic        O_rsp_valid;
    logic        I_rsp_ready;
    logic [31:0] O_rsp_data;
    logic [4:0]  O_rsp_addr;
    logic        O_rsp_err;
    logic        O_rsp_last;
    logic        O_halt_req;
    logic        I_halted;
    logic [4:0]  O_rf_rs1, O_rf_rs2, O_rf_rd;
    logic        O_rf_re, O_rf_we;
    logic [31:0] O_rf_data;
    logic [31:0] I_rf_regval1, I_rf_regval2;

    int checks = 0;
    int failures = 0;

    beat_t       got_q[$];
    beat_t       exp_q[$];
    int          we_cnt = 0, re_cnt = 0, bad_en = 0, unstable = 0;
    int          stall_pct = 0;
    logic [4:0]  last_we_rd;
    logic [31:0] last_we_data;
    logic [31:0] rf[32];
    logic [31:0] ref_rf[32];
    logic [31:0] pend1, pend2;
    bit          pend_v = 0;
    time         t_acc;

    regfile_debug_port #(.HALT_TIMEOUT(TMO)) dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n),
        .I_req_valid(I_req_valid), .O_req_ready(O_req_ready),
        .I_req_write(I_req_write), .I_req_dump(I_req_dump),
        .I_req_addr(I_req_addr), .I_req_wdata(I_req_wdata),
        .O_rsp_valid(O_rsp_valid), .I_rsp_ready(I_rsp_ready),
        .O_rsp_data(O_rsp_data), .O_rsp_addr(O_rsp_addr),
        .O_rsp_err(O_rsp_err), .O_rsp_last(O_rsp_last),
        .O_halt_req(O_halt_req), .I_halted(I_halted),
        .O_rf_rs1(O_rf_rs1), .O_rf_rs2(O_rf_rs2), .O_rf_rd(O_rf_rd),
        .O_rf_re(O_rf_re), .O_rf_we(O_rf_we), .O_rf_data(O_rf_data),
        .I_rf_regval1(I_rf_regval1), .I_rf_regval2(I_rf_regval2)
    );

    always #5 I_clk = ~I_clk;

    // Register-file read data is registered: sampled request becomes visible after the next edge.
    initial begin
        I_rf_regval1 = 32'd0;
        I_rf_regval2 = 32'd0;
        forever begin
            @(posedge I_clk);
            if (pend_v) begin
                I_rf_regval1 <= pend1;
                I_rf_regval2 <= pend2;
                pend_v = 0;
            end
        end
    end

    // Mid-cycle observer: register file behaviour, response collection, random backpressure.
    initial begin
        beat_t cur, prev;
        bit prev_stall;
        prev_stall = 0;
        prev = '0;
        I_rsp_ready = 1'b1;
        forever begin
            @(negedge I_clk);
            if ((O_rf_re || O_rf_we) && !I_halted) bad_en++;
            if (O_rf_we) begin
                we_cnt++;
                last_we_rd = O_rf_rd;
                last_we_data = O_rf_data;
                rf[O_rf_rd] = O_rf_data;
            end
            if (O_rf_re) begin
                re_cnt++;
                pend1 = rf[O_rf_rs1];
                pend2 = rf[O_rf_rs2];
                pend_v = 1;
            end
            cur = {O_rsp_data, O_rsp_addr, O_rsp_err, O_rsp_last};
            if (prev_stall && O_rsp_valid && cur !== prev) unstable++;
            I_rsp_ready = ($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
            if (O_rsp_valid && I_rsp_ready) got_q.push_back(cur);
            prev_stall = O_rsp_valid && !I_rsp_ready && I_rst_n;
            prev = cur;
        end
    end

    // Reference model: what the port must answer for a request, from the architectural rules.
    function automatic void model(input bit wr, input bit dp, input logic [4:0] a,
                                  input logic [31:0] wd, input bit halt_ok);
        if (!halt_ok) begin
            exp_q.push_back({32'd0, a, 1'b1, 1'b1});
        end else if (dp) begin
            for (int i = 0; i < 32; i++)
                exp_q.push_back({(i == 0) ? 32'd0 : ref_rf[i], 5'(i), 1'b0, (i == 31)});
        end else if (wr) begin
            if (a == 5'd0) begin
                exp_q.push_back({32'd0, 5'd0, 1'b1, 1'b1});
            end else begin
                ref_rf[a] = wd;
                exp_q.push_back({32'd0, a, 1'b0, 1'b1});
            end
        end else begin
            exp_q.push_back({ref_rf[a], a, 1'b0, 1'b1});
        end
    endfunction

    task automatic do_req(input bit wr, input bit dp, input logic [4:0] a,
                          input logic [31:0] wd, output bit ok);
        bit rdy;
        ok = 0;
        I_req_valid = 1'b1;
        I_req_write = wr;
        I_req_dump  = dp;
        I_req_addr  = a;
        I_req_wdata = wd;
        for (int i = 0; i < 50; i++) begin
            @(negedge I_clk);
            rdy = O_req_ready;
            @(posedge I_clk);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        t_acc = $time - 1;
        I_req_valid = 1'b0;
        I_req_write = 1'b0;
        I_req_dump  = 1'b0;
        I_req_addr  = 5'd0;
        I_req_wdata = 32'd0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge I_clk);
            if (got_q.size() >= n && !O_halt_req && !O_rsp_valid) begin
                ok = 1;
                break;
            end
        end
        @(posedge I_clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge I_clk);
            if (O_rsp_valid) begin
                lat = int'(($time - t_acc - 5) / 10);
                break;
            end
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {O_req_ready, O_rsp_valid, O_rsp_data, O_rsp_addr, O_rsp_err, O_rsp_last,
                O_halt_req, O_rf_rs1, O_rf_rs2, O_rf_rd, O_rf_re, O_rf_we, O_rf_data};
    endfunction

    task automatic test_reset();
        I_rst_n = 1'b0;
        I_req_valid = 0; I_req_write = 0; I_req_dump = 0; I_req_addr = 0; I_req_wdata = 0;
        I_halted = 1'b0;
        repeat (3) @(posedge I_clk);
        #1;
        checks++;
        if (all_outs() !== 128'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        I_rst_n = 1'b1;
        @(negedge I_clk);
        checks++;
        if (O_req_ready !== 1'b0) begin
            failures++; $display("FAIL ready_before_first_edge got=%b exp=0", O_req_ready);
        end
        @(posedge I_clk);
        #1;
        checks++;
        if (O_req_ready !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset got=%b exp=1", O_req_ready);
        end
    endtask

    task automatic test_read_basic();
        bit ok; int lat;
        I_halted = 1'b1; stall_pct = 0; got_q.delete();
        rf[5] = 32'hDEADBEEF; ref_rf[5] = 32'hDEADBEEF;
        do_req(0, 0, 5'd5, 32'd0, ok);
        wait_valid(lat);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL read_latency got=%0d exp=4", lat); end
        wait_done(1, 50, ok);
        checks++;
        if (!ok || got_q.size() != 1) begin
            failures++; $display("FAIL read_beat_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {32'hDEADBEEF, 5'd5, 1'b0, 1'b1}) begin
                failures++; $display("FAIL read_beat got=%h exp=%h", got_q[0], {32'hDEADBEEF, 5'd5, 1'b0, 1'b1});
            end
        end
        checks++;
        if (O_halt_req !== 1'b0) begin failures++; $display("FAIL read_halt_release got=%b exp=0", O_halt_req); end
    endtask

    task automatic test_write_read();
        bit ok; int w0;
        got_q.delete(); w0 = we_cnt;
        do_req(1, 0, 5'd31, 32'h12345678, ok);
        wait_done(1, 50, ok);
        ref_rf[31] = 32'h12345678;
        checks++;
        if (we_cnt - w0 != 1 || last_we_rd !== 5'd31 || last_we_data !== 32'h12345678) begin
            failures++; $display("FAIL write_pulse got cnt=%0d rd=%0d data=%h exp cnt=1 rd=31 data=12345678",
                                 we_cnt - w0, last_we_rd, last_we_data);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'd0, 5'd31, 1'b0, 1'b1}) begin
            failures++; $display("FAIL write_beat got n=%0d beat=%h exp n=1 beat=%h", got_q.size(),
                                 (got_q.size() > 0) ? got_q[0] : beat_t'('0), {32'd0, 5'd31, 1'b0, 1'b1});
        end
        got_q.delete();
        do_req(0, 0, 5'd31, 32'd0, ok);
        wait_done(1, 50, ok);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'h12345678, 5'd31, 1'b0, 1'b1}) begin
            failures++; $display("FAIL readback_beat got n=%0d beat=%h exp n=1 beat=%h", got_q.size(),
                                 (got_q.size() > 0) ? got_q[0] : beat_t'('0), {32'h12345678, 5'd31, 1'b0, 1'b1});
        end
    endtask

    task automatic test_write_x0();
        bit ok; int w0;
        got_q.delete(); w0 = we_cnt;
        do_req(1, 0, 5'd0, 32'hAAAA5555, ok);
        wait_done(1, 50, ok);
        checks++;
        if (we_cnt != w0) begin failures++; $display("FAIL x0_no_write got=%0d exp=0", we_cnt - w0); end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'd0, 5'd0, 1'b1, 1'b1}) begin
            failures++; $display("FAIL x0_err_beat got n=%0d beat=%h exp n=1 beat=%h", got_q.size(),
                                 (got_q.size() > 0) ? got_q[0] : beat_t'('0), {32'd0, 5'd0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_timeout();
        bit ok; int lat, r0, w0;
        got_q.delete(); r0 = re_cnt; w0 = we_cnt;
        I_halted = 1'b0;
        do_req(0, 0, 5'd9, 32'd0, ok);
        wait_valid(lat);
        checks++;
        if (lat != TMO) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, TMO); end
        wait_done(1, 50, ok);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'd0, 5'd9, 1'b1, 1'b1}) begin
            failures++; $display("FAIL timeout_beat got n=%0d beat=%h exp n=1 beat=%h", got_q.size(),
                                 (got_q.size() > 0) ? got_q[0] : beat_t'('0), {32'd0, 5'd9, 1'b1, 1'b1});
        end
        checks++;
        if (re_cnt != r0 || we_cnt != w0 || bad_en != 0) begin
            failures++; $display("FAIL timeout_no_access got re=%0d we=%0d bad=%0d exp 0 0 0", re_cnt - r0, we_cnt - w0, bad_en);
        end
        I_halted = 1'b1;
    endtask

    task automatic test_halt_delay();
        bit ok;
        got_q.delete();
        rf[7] = 32'hCAFE0007; ref_rf[7] = 32'hCAFE0007;
        I_halted = 1'b0;
        do_req(0, 0, 5'd7, 32'd0, ok);
        repeat (2) @(posedge I_clk);
        #1;
        I_halted = 1'b1;
        wait_done(1, 50, ok);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'hCAFE0007, 5'd7, 1'b0, 1'b1}) begin
            failures++; $display("FAIL halt_delay_beat got n=%0d beat=%h exp n=1 beat=%h", got_q.size(),
                                 (got_q.size() > 0) ? got_q[0] : beat_t'('0), {32'hCAFE0007, 5'd7, 1'b0, 1'b1});
        end
    endtask

    task automatic test_dump();
        bit ok; int u0, w0; beat_t e;
        got_q.delete(); u0 = unstable; w0 = we_cnt;
        for (int i = 0; i < 32; i++) begin rf[i] = 32'(i * 3); ref_rf[i] = 32'(i * 3); end
        rf[0] = 32'hBAD00000;
        stall_pct = 40;
        // Write flag set together with dump: the dump must win.
        do_req(1, 1, 5'($urandom_range(0, 31)), 32'hFFFFFFFF, ok);
        wait_done(32, 3000, ok);
        stall_pct = 0;
        checks++;
        if (got_q.size() != 32) begin
            failures++; $display("FAIL dump_beat_count got=%0d exp=32", got_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                e = {32'(i * 3), 5'(i), 1'b0, (i == 31)};
                checks++;
                if (got_q[i] !== e) begin
                    failures++; $display("FAIL dump_beat_%0d got=%h exp=%h", i, got_q[i], e);
                end
            end
        end
        checks++;
        if (unstable != u0) begin failures++; $display("FAIL dump_stall_stable got=%0d exp=0", unstable - u0); end
        checks++;
        if (we_cnt != w0 || bad_en != 0) begin
            failures++; $display("FAIL dump_no_write got we=%0d bad=%0d exp 0 0", we_cnt - w0, bad_en);
        end
    endtask

    task automatic test_random();
        bit ok; bit wr; logic [4:0] a; logic [31:0] wd; int k;
        stall_pct = 30;
        for (int n = 0; n < 25; n++) begin
            got_q.delete(); exp_q.delete();
            k  = $urandom_range(0, 9);
            wr = (k >= 4);
            a  = (k == 9) ? 5'd0 : 5'($urandom_range(1, 31));
            wd = $urandom;
            model(wr, 0, a, wd, 1);
            do_req(wr, 0, a, wd, ok);
            wait_done(exp_q.size(), 200, ok);
            checks++;
            if (got_q.size() != exp_q.size() || got_q[0] !== exp_q[0]) begin
                failures++; $display("FAIL random_op_%0d got n=%0d beat=%h exp n=%0d beat=%h", n, got_q.size(),
                                     (got_q.size() > 0) ? got_q[0] : beat_t'('0), exp_q.size(), exp_q[0]);
            end
        end
        stall_pct = 0;
        checks++;
        if (unstable != 0 || bad_en != 0) begin
            failures++; $display("FAIL random_protocol got unstable=%0d bad=%0d exp 0 0", unstable, bad_en);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int n0;
        stall_pct = 0; got_q.delete(); exp_q.delete();
        ref_rf[12] = 32'h0BAD_F00D;
        model(1, 0, 5'd12, 32'h0BADF00D, 1);
        model(0, 0, 5'd12, 32'd0, 1);
        model(1, 0, 5'd0,  32'h1, 1);
        do_req(1, 0, 5'd12, 32'h0BADF00D, ok);
        do_req(0, 0, 5'd12, 32'd0, ok);
        do_req(1, 0, 5'd0, 32'h1, ok);
        wait_done(3, 100, ok);
        n0 = got_q.size();
        checks++;
        if (n0 != 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", n0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL b2b_beat_%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        bit ok; int n0, w0;
        stall_pct = 0; got_q.delete();
        do_req(0, 1, 5'd0, 32'd0, ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge I_clk);
            if (got_q.size() >= 14) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_dump_reach got=%0d exp=14", got_q.size()); end
        @(posedge I_clk);
        #1;
        I_rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 128'd0) begin
            failures++; $display("FAIL mid_dump_reset_outputs got=%h exp=0", all_outs());
        end
        n0 = got_q.size(); w0 = we_cnt;
        repeat (3) @(posedge I_clk);
        #1;
        I_rst_n = 1'b1;
        repeat (5) @(posedge I_clk);
        #1;
        checks++;
        if (got_q.size() != n0 || we_cnt != w0) begin
            failures++; $display("FAIL mid_dump_no_more got beats=%0d we=%0d exp 0 0", got_q.size() - n0, we_cnt - w0);
        end
        got_q.delete();
        rf[20] = 32'h20202020; ref_rf[20] = 32'h20202020;
        do_req(0, 0, 5'd20, 32'd0, ok);
        wait_done(1, 50, ok);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'h20202020, 5'd20, 1'b0, 1'b1}) begin
            failures++; $display("FAIL post_reset_read got n=%0d beat=%h exp n=1 beat=%h", got_q.size(),
                                 (got_q.size() > 0) ? got_q[0] : beat_t'('0), {32'h20202020, 5'd20, 1'b0, 1'b1});
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i] = 32'h1000_0000 + 32'(i);
            ref_rf[i] = rf[i];
        end
        test_reset();
        test_read_basic();
        test_write_read();
        test_write_x0();
        test_timeout();
        test_halt_delay();
        test_dump();
        test_random();
        test_back_to_back();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
